// File: rtl/digitron_scan_driver.sv
// rtl/digitron_scan_driver.sv - multiplexed 7-segment scan driver with frame-aligned double buffering
module digitron_scan_driver #(
    parameter int NUM_DIGITS   = 4,      // digit positions scanned, 2..8
    parameter int SCAN_DIV     = 50000,  // CLK cycles per digit slot
    parameter int BLANK_CYC    = 500,    // all-off cycles at the start of each slot
    parameter int LZS          = 1,      // 1 = suppress leading zeros
    parameter int BLINK_FRAMES = 64      // frames per blink half-period
) (
    input  logic                    CLK,            // system clock
    input  logic                    RST,            // synchronous reset, active-high
    input  logic [4*NUM_DIGITS-1:0] data_in,        // hex nibbles, [3:0] = digit 0
    input  logic [NUM_DIGITS-1:0]   dp_in,          // decimal point per digit
    input  logic [NUM_DIGITS-1:0]   blink_in,       // blink enable per digit
    input  logic                    load,           // capture strobe
    output logic                    pending,        // captured value not yet shown
    output logic                    frame_done,     // pulse after the last slot of a frame
    output logic [7:0]              Digitron_Out,   // {dp,g,f,e,d,c,b,a}, active-high
    output logic [NUM_DIGITS-1:0]   DigitronCS_Out  // digit selects, active-low
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]        pre;
    logic [IDX_W-1:0]        idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    phase;

    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blink;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blink;

    logic                    slot_end;
    logic                    frame_end;
    logic                    in_gap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   cs_sel;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    upper_zero;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'h3f;
            4'h1:    seg_decode = 7'h06;
            4'h2:    seg_decode = 7'h5b;
            4'h3:    seg_decode = 7'h4f;
            4'h4:    seg_decode = 7'h66;
            4'h5:    seg_decode = 7'h6d;
            4'h6:    seg_decode = 7'h7d;
            4'h7:    seg_decode = 7'h07;
            4'h8:    seg_decode = 7'h7f;
            4'h9:    seg_decode = 7'h6f;
            4'ha:    seg_decode = 7'h77;
            4'hb:    seg_decode = 7'h7c;
            4'hc:    seg_decode = 7'h39;
            4'hd:    seg_decode = 7'h5e;
            4'he:    seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    assign slot_end  = (pre == PRE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign in_gap    = (32'(pre) < 32'(BLANK_CYC));

    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        // Walk down from the most significant digit; a digit is a leading zero
        // while every nibble from it upwards is zero. Digit 0 is never blanked.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (shadow_data[4*k +: 4] == 4'h0);
            lz_blank[k] = upper_zero;
        end

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cs_sel    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = shadow_data[4*k +: 4];
                cur_dp    = shadow_dp[k];
                cur_blank = ((LZS != 0) && lz_blank[k]) || (phase && shadow_blink[k]);
                cs_sel[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre            <= '0;
            idx            <= '0;
            blink_cnt      <= '0;
            phase          <= 1'b0;
            shadow_data    <= '0;
            shadow_dp      <= '0;
            shadow_blink   <= '0;
            pend_data      <= '0;
            pend_dp        <= '0;
            pend_blink     <= '0;
            pending        <= 1'b0;
            frame_done     <= 1'b0;
            Digitron_Out   <= 8'h00;
            DigitronCS_Out <= '1;
        end else begin
            pre <= slot_end ? '0 : pre + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            frame_done <= frame_end;

            if (frame_end) begin
                if (pending) begin
                    shadow_data  <= pend_data;
                    shadow_dp    <= pend_dp;
                    shadow_blink <= pend_blink;
                end
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            // A load on the boundary cycle lands in pend_reg after the older
            // value has been moved to the shadow, so it waits one more frame.
            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blink <= blink_in;
                pending    <= 1'b1;
            end else if (frame_end) begin
                pending    <= 1'b0;
            end

            if (in_gap) begin
                DigitronCS_Out <= '1;
                Digitron_Out   <= 8'h00;
            end else begin
                DigitronCS_Out <= cs_sel;
                Digitron_Out   <= cur_blank ? 8'h00 : {cur_dp, seg_decode(cur_nib)};
            end
        end
    end

endmodule

// File: tb/tb_digitron_scan_driver.sv
// tb/tb_digitron_scan_driver.sv - self-checking bench for digitron_scan_driver
module tb_digitron_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = ND * SD;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_in;
    logic        load;
    logic        pending0, fd0, pending1, fd1;
    logic [7:0]  seg0, seg1;
    logic [3:0]  cs0, cs1;

    int tests  = 0;
    int failed = 0;

    always #5 CLK = ~CLK;

    digitron_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .LZS(0), .BLINK_FRAMES(BF)) u_lzs0 (
        .CLK(CLK), .RST(RST), .data_in(data_in), .dp_in(dp_in), .blink_in(blink_in), .load(load),
        .pending(pending0), .frame_done(fd0), .Digitron_Out(seg0), .DigitronCS_Out(cs0));

    digitron_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .LZS(1), .BLINK_FRAMES(BF)) u_lzs1 (
        .CLK(CLK), .RST(RST), .data_in(data_in), .dp_in(dp_in), .blink_in(blink_in), .load(load),
        .pending(pending1), .frame_done(fd1), .Digitron_Out(seg1), .DigitronCS_Out(cs1));

    // Reference model: every load is kept with the edge it was taken on and the
    // first frame that displays it; outputs follow from the elapsed edge count.
    typedef struct {
        int          e;
        int          eff;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
    } load_t;

    load_t      loads[$];
    int         c = 0;
    logic [6:0] seg_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                 7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    task automatic cyc();
        load_t l;
        @(posedge CLK);
        if (RST) begin
            c = 0;
            loads.delete();
        end else begin
            if (load) begin
                l.e   = c;
                l.eff = (c + 1) / FRAME + 1;
                l.d   = data_in;
                l.dp  = dp_in;
                l.bl  = blink_in;
                loads.push_back(l);
            end
            c++;
        end
        @(negedge CLK);
    endtask

    function automatic void frame_value(input int f, output logic [15:0] d,
                                        output logic [3:0] dp, output logic [3:0] bl);
        int best = -1;
        d = '0; dp = '0; bl = '0;
        foreach (loads[i]) begin
            if (loads[i].eff <= f && loads[i].e > best) begin
                best = loads[i].e;
                d    = loads[i].d;
                dp   = loads[i].dp;
                bl   = loads[i].bl;
            end
        end
    endfunction

    function automatic void expect_out(input bit lz, output logic [3:0] ecs, output logic [7:0] eseg);
        int p, i, f;
        logic [15:0] d;
        logic [3:0]  dp, bl;
        ecs  = 4'hF;
        eseg = 8'h00;
        if (c == 0) return;
        p = (c - 1) % SD;
        i = ((c - 1) / SD) % ND;
        f = (c - 1) / FRAME;
        if (p < BC) return;
        frame_value(f, d, dp, bl);
        ecs = ~(4'b0001 << i);
        if ((lz && i > 0 && (d >> (4 * i)) == 16'h0) || (((f / BF) % 2) == 1 && bl[i]))
            eseg = 8'h00;
        else
            eseg = {dp[i], seg_tab[d[4*i +: 4]]};
    endfunction

    function automatic logic exp_pending();
        exp_pending = 1'b0;
        foreach (loads[i]) if (FRAME * loads[i].eff > c) exp_pending = 1'b1;
    endfunction

    function automatic logic exp_fd();
        exp_fd = (c > 0) && (c % FRAME == 0);
    endfunction

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in = d; dp_in = dp; blink_in = bl; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_cs;
        RST = 1'b1;
        repeat (3) begin
            cyc();
            tests++;
            if (cs0 !== 4'hF || seg0 !== 8'h00 || cs1 !== 4'hF || seg1 !== 8'h00 ||
                pending0 !== 1'b0 || fd0 !== 1'b0)
                begin failed++; $display("FAIL reset_hold cs=%h seg=%h pend=%b fd=%b required cs=f seg=00 pend=0 fd=0", cs0, seg0, pending0, fd0); end
        end
        RST = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            exp_cs = (k == 3) ? 4'b1110 : 4'b1111;
            tests++;
            if (cs0 !== exp_cs || cs1 !== exp_cs)
                begin failed++; $display("FAIL reset_release k=%0d cs0=%b cs1=%b required %b", k, cs0, cs1, exp_cs); end
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] ecs; logic [7:0] eseg;
        logic [7:0] want_seg [4] = '{8'h66, 8'h4f, 8'h5b, 8'h06};
        logic [7:0] seen_seg [4];
        int         cnt [4];
        int         order [$];
        for (int k = 0; k < 4; k++) begin cnt[k] = 0; seen_seg[k] = 8'hxx; end
        do_load(16'h1234, 4'h0, 4'h0);
        for (int k = 0; k < 2 * FRAME && c < 2 * FRAME; k++) begin
            cyc();
            expect_out(1'b0, ecs, eseg);
            tests++;
            if (cs0 !== ecs || seg0 !== eseg)
                begin failed++; $display("FAIL scan_model c=%0d cs=%b seg=%h required %b %h", c, cs0, seg0, ecs, eseg); end
            if (c > FRAME) begin
                for (int d = 0; d < 4; d++) begin
                    if (cs0 === ~(4'b0001 << d)) begin
                        if (cnt[d] == 0) order.push_back(d);
                        cnt[d]++;
                        seen_seg[d] = seg0;
                    end
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (cnt[d] != 6 || seen_seg[d] !== want_seg[d])
                begin failed++; $display("FAIL scan_digit%0d active=%0d seg=%h required 6 %h", d, cnt[d], seen_seg[d], want_seg[d]); end
        end
        tests++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3)
            begin failed++; $display("FAIL scan_sequence got %0d digits required order 0,1,2,3", order.size()); end
    endtask

    task automatic test_frame_update();
        logic [3:0] ecs; logic [7:0] eseg;
        int pulses = 0;
        for (int k = 0; k < FRAME && (c % FRAME) != 10; k++) cyc();
        do_load(16'hABCD, 4'h0, 4'h0);
        repeat (5) cyc();
        do_load(16'h00F0, 4'h0, 4'h0);
        for (int k = 0; k < 2 * FRAME; k++) begin
            cyc();
            if (fd0 === 1'b1) pulses++;
            expect_out(1'b0, ecs, eseg);
            tests++;
            if (pending0 !== exp_pending() || fd0 !== exp_fd() || cs0 !== ecs || seg0 !== eseg)
                begin failed++; $display("FAIL update c=%0d pend=%b fd=%b cs=%b seg=%h required %b %b %b %h", c, pending0, fd0, cs0, seg0, exp_pending(), exp_fd(), ecs, eseg); end
        end
        tests++;
        if (pulses != 2)
            begin failed++; $display("FAIL frame_done_count got %0d required 2", pulses); end
    endtask

    task automatic test_lzs();
        logic [3:0] ecs; logic [7:0] eseg;
        logic [15:0] vals [4];
        vals[0] = 16'h0040;
        vals[1] = 16'h0000;
        for (int v = 2; v < 4; v++)
            for (int n = 0; n < 4; n++)
                vals[v][4*n +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        for (int v = 0; v < 4; v++) begin
            do_load(vals[v], 4'h0, 4'h0);
            for (int k = 0; k < 2 * FRAME; k++) begin
                cyc();
                expect_out(1'b1, ecs, eseg);
                tests++;
                if (cs1 !== ecs || seg1 !== eseg)
                    begin failed++; $display("FAIL lzs data=%h c=%0d cs=%b seg=%h required %b %h", vals[v], c, cs1, seg1, ecs, eseg); end
            end
        end
    endtask

    task automatic test_dp_blink();
        logic [3:0] ecs0, ecs1; logic [7:0] eseg0, eseg1;
        do_load(16'h5678, 4'b0010, 4'b0001);
        for (int k = 0; k < 5 * FRAME; k++) begin
            cyc();
            expect_out(1'b0, ecs0, eseg0);
            expect_out(1'b1, ecs1, eseg1);
            tests++;
            if (cs0 !== ecs0 || seg0 !== eseg0 || cs1 !== ecs1 || seg1 !== eseg1)
                begin failed++; $display("FAIL dp_blink c=%0d seg0=%h seg1=%h required %h %h", c, seg0, seg1, eseg0, eseg1); end
        end
    endtask

    task automatic test_boundary_load();
        logic [3:0] ecs; logic [7:0] eseg;
        for (int k = 0; k < FRAME && (c % FRAME) != 10; k++) cyc();
        do_load(16'($urandom), 4'($urandom), 4'h0);
        for (int k = 0; k < FRAME && (c % FRAME) != FRAME - 1; k++) cyc();
        do_load(16'($urandom), 4'($urandom), 4'h0);
        tests++;
        if (pending0 !== 1'b1 || fd0 !== 1'b1)
            begin failed++; $display("FAIL boundary_load pend=%b fd=%b required 1 1", pending0, fd0); end
        for (int k = 0; k < 2 * FRAME + 6; k++) begin
            cyc();
            expect_out(1'b0, ecs, eseg);
            tests++;
            if (pending0 !== exp_pending() || cs0 !== ecs || seg0 !== eseg)
                begin failed++; $display("FAIL boundary_apply c=%0d pend=%b cs=%b seg=%h required %b %b %h", c, pending0, cs0, seg0, exp_pending(), ecs, eseg); end
        end
    endtask

    task automatic test_reset_pending();
        logic [3:0] ecs0, ecs1; logic [7:0] eseg0, eseg1;
        do_load(16'h9ABC, 4'hF, 4'h0);
        repeat (3) cyc();
        tests++;
        if (pending0 !== 1'b1)
            begin failed++; $display("FAIL pend_before_reset pend=%b required 1", pending0); end
        RST = 1'b1;
        repeat (2) cyc();
        RST = 1'b0;
        tests++;
        if (pending0 !== 1'b0 || pending1 !== 1'b0 || cs0 !== 4'hF || seg0 !== 8'h00)
            begin failed++; $display("FAIL reset_pending pend=%b cs=%b seg=%h required 0 1111 00", pending0, cs0, seg0); end
        for (int k = 0; k < 2 * FRAME; k++) begin
            cyc();
            expect_out(1'b0, ecs0, eseg0);
            expect_out(1'b1, ecs1, eseg1);
            tests++;
            if (pending0 !== 1'b0 || cs0 !== ecs0 || seg0 !== eseg0 || cs1 !== ecs1 || seg1 !== eseg1)
                begin failed++; $display("FAIL after_reset c=%0d pend=%b seg0=%h seg1=%h required 0 %h %h", c, pending0, seg0, seg1, eseg0, eseg1); end
        end
    endtask

    task automatic test_random();
        logic [3:0] ecs0, ecs1; logic [7:0] eseg0, eseg1;
        for (int k = 0; k < 600; k++) begin
            load     = ($urandom_range(0, 9) == 0);
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            blink_in = 4'($urandom);
            RST      = ($urandom_range(0, 299) == 0);
            cyc();
            load = 1'b0;
            RST  = 1'b0;
            expect_out(1'b0, ecs0, eseg0);
            expect_out(1'b1, ecs1, eseg1);
            tests++;
            if (pending0 !== exp_pending() || pending1 !== exp_pending() || fd0 !== exp_fd() || fd1 !== exp_fd() ||
                cs0 !== ecs0 || seg0 !== eseg0 || cs1 !== ecs1 || seg1 !== eseg1)
                begin failed++; $display("FAIL random c=%0d pend=%b fd=%b cs0=%b seg0=%h cs1=%b seg1=%h required %b %b %b %h %b %h", c, pending0, fd0, cs0, seg0, cs1, seg1, exp_pending(), exp_fd(), ecs0, eseg0, ecs1, eseg1); end
        end
    endtask

    initial begin
        RST = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blink_in = '0;
        test_reset();
        test_scan_order();
        test_frame_update();
        test_lzs();
        test_dp_blink();
        test_boundary_load();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
